// File: rtl/rv32_pkg.sv
// Shared RV32IM definitions: bubble instruction, major opcodes and the fetch FSM encoding.
package rv32_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      S_INIT    = 2'd0,
      S_FETCH   = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_e;

   // Instruction fetches are word aligned; stray low address bits are dropped.
   function automatic logic [31:0] alignWord(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_pc_unit.sv
// Program counter: reset value, redirect load with word alignment, and +4 advance.
module pc_unit
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_load,
   input  logic [31:0] i_target,
   input  logic        i_incr,
   output logic [31:0] o_pc
);

   logic [31:0] r_pc;

   // Redirect outranks the sequential advance; the +4 wraps naturally at 2^32.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc <= RESET_PC;
      end else if (i_load) begin
         r_pc <= alignWord(i_target);
      end else if (i_incr) begin
         r_pc <= r_pc + 32'd4;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, instruction-memory requests, IF/ID register,
// one-entry stall hold buffer and redirect handling with in-flight discard.
module if_stage
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_imem_busywait,
   input  logic [31:0] i_imem_instr,
   output logic        o_imem_read,
   output logic [31:0] o_imem_addr,
   output logic [31:0] o_ifid_pc,
   output logic [31:0] o_ifid_instr,
   output logic        o_ifid_valid,
   output logic [6:0]  o_opcode,
   output logic [2:0]  o_func3,
   output logic [6:0]  o_func7,
   output logic        o_fetch_busy
);

   fetch_state_e r_state;
   logic         r_holdFull;
   logic [31:0]  r_holdPc;
   logic [31:0]  r_holdInstr;
   logic [31:0]  r_ifidPc;
   logic [31:0]  r_ifidInstr;
   logic         r_ifidValid;
   logic [31:0]  r_discardAddr;

   logic [31:0]  w_pc;
   logic         w_fetchActive;
   logic         w_complete;
   logic         w_discarding;

   assign w_fetchActive = (r_state == S_FETCH) && !r_holdFull;
   assign w_discarding  = (r_state == S_DISCARD);
   assign w_complete    = w_fetchActive && !i_imem_busywait;

   pc_unit #(
      .RESET_PC (RESET_PC)
   ) u_pc_unit (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_load   (i_redirect),
      .i_target (i_redirect_pc),
      .i_incr   (w_complete),
      .o_pc     (w_pc)
   );

   // A discarded access keeps its original address until memory finishes it.
   assign o_imem_read  = w_fetchActive || w_discarding;
   assign o_imem_addr  = w_discarding ? r_discardAddr : w_pc;
   assign o_fetch_busy = (w_fetchActive && i_imem_busywait) || w_discarding;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_INIT;
         r_holdFull    <= 1'b0;
         r_holdPc      <= 32'd0;
         r_holdInstr   <= NOP_INSTR;
         r_ifidPc      <= 32'd0;
         r_ifidInstr   <= NOP_INSTR;
         r_ifidValid   <= 1'b0;
         r_discardAddr <= 32'd0;
      end else begin
         unique case (r_state)
            S_INIT: r_state <= S_FETCH;
            S_FETCH: begin
               if (i_redirect && w_fetchActive && i_imem_busywait) begin
                  r_state       <= S_DISCARD;
                  r_discardAddr <= w_pc;
               end
            end
            S_DISCARD: begin
               if (!i_imem_busywait) begin
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_INIT;
         endcase

         // Redirect flushes IF/ID and the hold buffer even while stalled.
         if (i_redirect) begin
            r_ifidInstr <= NOP_INSTR;
            r_ifidValid <= 1'b0;
            r_holdFull  <= 1'b0;
         end else if (w_fetchActive) begin
            if (!i_imem_busywait) begin
               if (!i_stall) begin
                  r_ifidPc    <= w_pc;
                  r_ifidInstr <= i_imem_instr;
                  r_ifidValid <= 1'b1;
               end else begin
                  r_holdPc    <= w_pc;
                  r_holdInstr <= i_imem_instr;
                  r_holdFull  <= 1'b1;
               end
            end else if (!i_stall) begin
               r_ifidInstr <= NOP_INSTR;
               r_ifidValid <= 1'b0;
            end
         end else if (r_holdFull && (r_state == S_FETCH) && !i_stall) begin
            r_ifidPc    <= r_holdPc;
            r_ifidInstr <= r_holdInstr;
            r_ifidValid <= 1'b1;
            r_holdFull  <= 1'b0;
         end else if (w_discarding) begin
            r_ifidInstr <= NOP_INSTR;
            r_ifidValid <= 1'b0;
         end
      end
   end

   assign o_ifid_pc    = r_ifidPc;
   assign o_ifid_instr = r_ifidInstr;
   assign o_ifid_valid = r_ifidValid;
   assign o_opcode     = r_ifidInstr[6:0];
   assign o_func3      = r_ifidInstr[14:12];
   assign o_func7      = r_ifidInstr[31:25];

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed stimulus pushes expected memory
// transactions and IF/ID deliveries; a negedge monitor pops and compares them.
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        busy;
   logic [31:0] imemInstr;
   logic        imemRead;
   logic [31:0] imemAddr;
   logic [31:0] ifidPc;
   logic [31:0] ifidInstr;
   logic        ifidValid;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic        fetchBusy;

   int checks = 0;
   int errors = 0;

   logic [31:0] expAddr[$];
   logic [63:0] expDeliver[$];
   logic        prevStall = 1'b0;

   if_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_stall         (stall),
      .i_redirect      (redirect),
      .i_redirect_pc   (redirectPc),
      .i_imem_busywait (busy),
      .i_imem_instr    (imemInstr),
      .o_imem_read     (imemRead),
      .o_imem_addr     (imemAddr),
      .o_ifid_pc       (ifidPc),
      .o_ifid_instr    (ifidInstr),
      .o_ifid_valid    (ifidValid),
      .o_opcode        (opcode),
      .o_func3         (func3),
      .o_func7         (func7),
      .o_fetch_busy    (fetchBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image: two real instructions at the bottom, an address-tagged R-type elsewhere.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      if (addr == 32'h0) return 32'h00A00093;
      if (addr == 32'h4) return 32'h40208133;
      return {addr[24:0], 7'b0110011};
   endfunction

   always_comb imemInstr = memWord(imemAddr);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Inputs change just after the rising edge; the task returns at the following falling edge.
   task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                input logic [31:0] rpc, input logic bw);
      @(posedge clk);
      #2;
      rst        = r;
      stall      = s;
      redirect   = rd;
      redirectPc = rpc;
      busy       = bw;
      @(negedge clk);
      #1;
   endtask

   // Monitor: completed memory transactions and fresh IF/ID deliveries are scored.
   always @(negedge clk) begin
      if (imemRead && !busy) begin
         if (expAddr.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedFetch: got addr %h, expected none", imemAddr);
         end else begin
            checkOutput("fetchAddr", imemAddr, expAddr.pop_front());
         end
      end
      if (ifidValid && !prevStall) begin
         if (expDeliver.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedDeliver: got pc %h instr %h, expected none", ifidPc, ifidInstr);
         end else begin
            logic [63:0] e;
            e = expDeliver.pop_front();
            checkOutput("ifidPc", ifidPc, e[63:32]);
            checkOutput("ifidInstr", ifidInstr, e[31:0]);
         end
      end
      prevStall = stall;
   end

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 32'h0; busy = 1'b0;

      expAddr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
                  32'h20, 32'h100, 32'h104, 32'h0, 32'hFFFF_FFFC, 32'h0};
      expDeliver = '{{32'h0, 32'h00A00093}, {32'h4, 32'h40208133},
                     {32'h8, memWord(32'h8)}, {32'hC, memWord(32'hC)},
                     {32'h10, memWord(32'h10)}, {32'h14, memWord(32'h14)},
                     {32'h18, memWord(32'h18)}, {32'h1C, memWord(32'h1C)},
                     {32'h100, memWord(32'h100)},
                     {32'hFFFF_FFFC, memWord(32'hFFFF_FFFC)}, {32'h0, 32'h00A00093}};

      // Reset state and the one idle INIT cycle
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("rstRead", 32'(imemRead), 32'd0);
      checkOutput("rstValid", 32'(ifidValid), 32'd0);
      checkOutput("rstInstr", ifidInstr, 32'h13);
      checkOutput("rstPc", ifidPc, 32'h0);
      checkOutput("rstBusy", 32'(fetchBusy), 32'd0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("initRead", 32'(imemRead), 32'd0);

      // Zero-wait fetches of 0x0 and 0x4, then 0x8 waits three cycles
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("firstRead", 32'(imemRead), 32'd1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("opcodeAddi", 32'(opcode), 32'b0010011);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("func7Sub", 32'(func7), 32'b0100000);
      checkOutput("func3Sub", 32'(func3), 32'b000);
      checkOutput("busyWait0", 32'(fetchBusy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, (i < 2) ? 1'b1 : 1'b0);
         checkOutput("waitAddr", imemAddr, 32'h8);
         checkOutput("waitValid", 32'(ifidValid), 32'd0);
         checkOutput("waitInstr", ifidInstr, 32'h13);
         checkOutput("waitBusy", 32'(fetchBusy), (i < 2) ? 32'd1 : 32'd0);
      end

      // Stall on the cycle 0xC completes, held two cycles
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("stallAddr", imemAddr, 32'hC);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("holdRead", 32'(imemRead), 32'd0);
      checkOutput("holdIfidPc", ifidPc, 32'h8);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("holdRead2", 32'(imemRead), 32'd0);
      checkOutput("holdIfidPc2", ifidPc, 32'h8);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("releaseAddr", imemAddr, 32'h10);

      // Sequential fetches up to 0x20, which is redirected while in flight
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'h103, 1);
      checkOutput("inflightAddr", imemAddr, 32'h20);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, (i < 2) ? 1'b1 : 1'b0);
         checkOutput("discardAddr", imemAddr, 32'h20);
         checkOutput("discardRead", 32'(imemRead), 32'd1);
         checkOutput("discardBusy", 32'(fetchBusy), 32'd1);
         checkOutput("discardValid", 32'(ifidValid), 32'd0);
      end

      // Fetch resumes at the aligned target; then redirect+stall together
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("alignedAddr", imemAddr, 32'h100);
      checkOutput("alignedValid", 32'(ifidValid), 32'd0);
      applyStimulus(0, 1, 1, 32'h300, 1);
      applyStimulus(0, 0, 1, 32'h200, 1);
      checkOutput("redirStallValid", 32'(ifidValid), 32'd0);
      checkOutput("redirStallInstr", ifidInstr, 32'h13);
      checkOutput("redirStallAddr", imemAddr, 32'h104);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("discard2Addr", imemAddr, 32'h104);
      applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 1);
      checkOutput("secondRedirAddr", imemAddr, 32'h200);

      // Reset in the middle of a discard
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("preRstAddr", imemAddr, 32'h200);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("midRstRead", 32'(imemRead), 32'd0);
      checkOutput("midRstValid", 32'(ifidValid), 32'd0);
      checkOutput("midRstBusy", 32'(fetchBusy), 32'd0);
      applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0);
      checkOutput("postRstAddr", imemAddr, 32'h0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("topAddr", imemAddr, 32'hFFFF_FFFC);
      checkOutput("topValid", 32'(ifidValid), 32'd0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("wrapAddr", imemAddr, 32'h0);
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("finalRead", 32'(imemRead), 32'd0);

      checkOutput("addrQueueEmpty", 32'(expAddr.size()), 32'd0);
      checkOutput("deliverQueueEmpty", 32'(expDeliver.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
